// File: rtl/ws2812_tx.sv
// WS2812 serial LED transmitter: 4-byte FIFO, MSB-first bit shaping and latch/reset low time.
// Register map: 0x0 push / status, 0x1 control (latch, clear overflow, flush) / latch_pend.
module ws2812_tx #(
   parameter int T0H_CYC = 22,
   parameter int T1H_CYC = 45,
   parameter int BIT_CYC = 80,
   parameter int RES_CYC = 3840
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] address,
   input  logic [7:0] data_in,
   input  logic       data_write,
   output logic [7:0] data_out,
   output logic [7:0] uo_out
);

   localparam logic [11:0] T0H_LAST = 12'(T0H_CYC - 1);
   localparam logic [11:0] T1H_LAST = 12'(T1H_CYC - 1);
   localparam logic [11:0] BIT_LAST = 12'(BIT_CYC - 1);
   localparam logic [11:0] RES_LAST = 12'(RES_CYC - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

   state_t      state_reg;
   logic [7:0]  fifo_mem [4];
   logic [1:0]  wr_ptr_reg;
   logic [1:0]  rd_ptr_reg;
   logic [2:0]  level_reg;
   logic        overflow_reg;
   logic        latch_pend_reg;
   logic        dout_reg;
   logic        busy_reg;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt_reg;
   logic [11:0] cnt_reg;

   logic        fifo_empty;
   logic        fifo_full;
   logic        wr_data;
   logic        wr_ctrl;
   logic        latch_set;
   logic        ovf_clr;
   logic        flush;
   logic        bit_end;
   logic        byte_end;
   logic        latch_done;
   logic        pop;
   logic        push_ok;
   logic        push_drop;
   logic [11:0] high_last;
   logic [2:0]  level_next;

   always_comb begin
      fifo_empty = (level_reg == 3'd0);
      fifo_full  = (level_reg == 3'd4);
      wr_data    = data_write && (address == 4'h0);
      wr_ctrl    = data_write && (address == 4'h1);
      latch_set  = wr_ctrl && data_in[0];
      ovf_clr    = wr_ctrl && data_in[1];
      flush      = wr_ctrl && data_in[2];
      high_last  = shift_reg[7] ? T1H_LAST : T0H_LAST;
      bit_end    = (state_reg == LOW) && (cnt_reg == BIT_LAST);
      byte_end   = bit_end && (bit_cnt_reg == 3'd7);
      latch_done = (state_reg == LATCH) && (cnt_reg == RES_LAST);
      // A pop frees a slot in the same cycle, so a push into a full FIFO can still land.
      pop        = !fifo_empty && ((state_reg == IDLE) || byte_end);
      push_ok    = wr_data && (!fifo_full || pop);
      push_drop  = wr_data && !push_ok;
      level_next = level_reg + 3'(push_ok) - 3'(pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= 2'd0;
         rd_ptr_reg   <= 2'd0;
         level_reg    <= 3'd0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 2'd1;
         end
         // Flush and push cannot coincide (different addresses), so rd_ptr may snap to wr_ptr.
         if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            level_reg  <= 3'd0;
         end else begin
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            level_reg <= level_next;
         end
         if (push_drop) begin
            overflow_reg <= 1'b1;
         end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         latch_pend_reg <= 1'b0;
         dout_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         shift_reg      <= 8'h00;
         bit_cnt_reg    <= 3'd0;
         cnt_reg        <= 12'd0;
      end else begin
         // A new request in the exit cycle of LATCH wins over the clear.
         if (latch_set) begin
            latch_pend_reg <= 1'b1;
         end else if (latch_done) begin
            latch_pend_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (pop) begin
                  shift_reg   <= fifo_mem[rd_ptr_reg];
                  bit_cnt_reg <= 3'd0;
                  cnt_reg     <= 12'd0;
                  state_reg   <= HIGH;
                  dout_reg    <= 1'b1;
                  busy_reg    <= 1'b1;
               end else if (latch_pend_reg) begin
                  cnt_reg   <= 12'd0;
                  state_reg <= LATCH;
                  dout_reg  <= 1'b0;
                  busy_reg  <= 1'b1;
               end
            end

            HIGH: begin
               cnt_reg <= cnt_reg + 12'd1;
               if (cnt_reg == high_last) begin
                  state_reg <= LOW;
                  dout_reg  <= 1'b0;
               end
            end

            LOW: begin
               if (bit_end) begin
                  cnt_reg <= 12'd0;
                  if (!byte_end) begin
                     shift_reg   <= {shift_reg[6:0], 1'b0};
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     state_reg   <= HIGH;
                     dout_reg    <= 1'b1;
                  end else if (pop) begin
                     shift_reg   <= fifo_mem[rd_ptr_reg];
                     bit_cnt_reg <= 3'd0;
                     state_reg   <= HIGH;
                     dout_reg    <= 1'b1;
                  end else if (latch_pend_reg) begin
                     state_reg <= LATCH;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 12'd1;
               end
            end

            LATCH: begin
               if (latch_done) begin
                  cnt_reg   <= 12'd0;
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 12'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               dout_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      data_out = 8'h00;
      case (address)
         4'h0:    data_out = {1'b0, level_reg, overflow_reg, fifo_empty, fifo_full, busy_reg};
         4'h1:    data_out = {7'b0, latch_pend_reg};
         default: data_out = 8'h00;
      endcase
   end

   assign uo_out = {6'b0, busy_reg, dout_reg};

endmodule

// File: tb/tb_ws2812_tx.sv
// Self-checking bench for ws2812_tx: byte/elapsed-time reference model compared every cycle,
// directed literal checks, then randomized register traffic.
module tb_ws2812_tx;

   localparam int BITC = 80;
   localparam int RESC = 3840;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_write = 1'b0;
   logic [3:0] address = 4'h0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic [7:0] uo_out;

   int n_cmp = 0;
   int n_bad = 0;

   ws2812_tx dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .data_in    (data_in),
      .data_write (data_write),
      .data_out   (data_out),
      .uo_out     (uo_out)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: mode 0 idle, 1 sending m_cur (m_e cycles elapsed), 2 latch low time.
   int         m_q[$];
   bit         m_ovf;
   bit         m_lp;
   bit         m_valid = 1'b0;
   int         m_mode;
   int         m_e;
   logic [7:0] m_cur;
   int         m_old_size;
   bit         m_popped;
   bit         m_latch_end;

   task automatic m_start_byte();
      m_cur    = 8'(m_q.pop_front());
      m_mode   = 1;
      m_e      = 0;
      m_popped = 1'b1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_ovf   = 1'b0;
         m_lp    = 1'b0;
         m_mode  = 0;
         m_e     = 0;
         m_cur   = 8'h00;
         m_valid = 1'b1;
      end else begin
         m_old_size  = m_q.size();
         m_popped    = 1'b0;
         m_latch_end = 1'b0;
         case (m_mode)
            0: begin
               if (m_old_size > 0) m_start_byte();
               else if (m_lp) begin m_mode = 2; m_e = 0; end
            end
            1: begin
               if (m_e == 8 * BITC - 1) begin
                  if (m_old_size > 0) m_start_byte();
                  else if (m_lp) begin m_mode = 2; m_e = 0; end
                  else m_mode = 0;
               end else m_e++;
            end
            default: begin
               if (m_e == RESC - 1) begin m_mode = 0; m_latch_end = 1'b1; end
               else m_e++;
            end
         endcase
         if (data_write && address == 4'h0) begin
            if (m_old_size < 4 || m_popped) m_q.push_back(int'(data_in));
            else m_ovf = 1'b1;
         end
         if (m_latch_end) m_lp = 1'b0;
         if (data_write && address == 4'h1) begin
            if (data_in[2]) m_q.delete();
            if (data_in[1]) m_ovf = 1'b0;
            if (data_in[0]) m_lp = 1'b1;
         end
      end
   end

   function automatic logic [7:0] exp_uo();
      int b;
      int th;
      if (m_mode == 0) return 8'h00;
      if (m_mode == 2) return 8'h02;
      b  = 7 - m_e / BITC;
      th = m_cur[b] ? 45 : 22;
      return {6'b0, 1'b1, ((m_e % BITC) < th)};
   endfunction

   function automatic logic [7:0] exp_do(input logic [3:0] a);
      int sz;
      sz = m_q.size();
      if (a == 4'h0)
         return {1'b0, 3'(sz), m_ovf, (sz == 0), (sz == 4), (m_mode != 0)};
      if (a == 4'h1)
         return {7'b0, m_lp};
      return 8'h00;
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("uo_out", 32'(uo_out), 32'(exp_uo()));
         check("data_out", 32'(data_out), 32'(exp_do(address)));
      end
   end

   task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
      rst        = r;
      data_write = w;
      address    = a;
      data_in    = d;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (uo_out[1] && n < budget) begin
         drive(1'b0, 1'b0, 4'h0, 8'h00);
         n++;
      end
      check("wait_idle", 32'(uo_out[1]), 32'd0);
   endtask

   int exp_a5[8] = '{45, 22, 45, 22, 22, 45, 22, 45};
   int runs[$];
   int run_len;
   int first_high;
   int busy_cnt;
   int high_cnt;
   int r;

   initial begin
      repeat (3) drive(1'b1, 1'b0, 4'h0, 8'h00);
      drive(1'b0, 1'b0, 4'h0, 8'h00);
      check("reset_status", 32'(data_out), 32'h04);
      check("reset_uo", 32'(uo_out), 32'h00);

      // Single byte 0xA5: rise one cycle after the push is registered, eight shaped pulses.
      drive(1'b0, 1'b1, 4'h0, 8'hA5);
      first_high = -1;
      busy_cnt   = 0;
      run_len    = 0;
      for (int i = 0; i < 700; i++) begin
         if (uo_out[0]) begin
            if (first_high < 0) first_high = i;
            run_len++;
         end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
         end
         if (uo_out[1]) busy_cnt++;
         drive(1'b0, 1'b0, 4'h0, 8'h00);
      end
      check("a5_first_high", 32'(first_high), 32'd1);
      check("a5_busy_cycles", 32'(busy_cnt), 32'd640);
      check("a5_pulse_count", 32'(runs.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         check("a5_pulse_len", (i < runs.size()) ? 32'(runs[i]) : 32'd0, 32'(exp_a5[i]));

      // 0xFF followed by a latch request: 640 + 3840 busy cycles, 8*45 high cycles.
      drive(1'b0, 1'b1, 4'h0, 8'hFF);
      drive(1'b0, 1'b1, 4'h1, 8'h01);
      busy_cnt = 0;
      high_cnt = 0;
      for (int i = 0; i < 4600; i++) begin
         if (uo_out[1]) busy_cnt++;
         if (uo_out[0]) high_cnt++;
         drive(1'b0, 1'b0, 4'h0, 8'h00);
      end
      check("latch_busy_cycles", 32'(busy_cnt), 32'd4480);
      check("latch_high_cycles", 32'(high_cnt), 32'd360);
      drive(1'b0, 1'b0, 4'h1, 8'h00);
      check("latch_pend_cleared", 32'(data_out), 32'h00);

      // Five pushes while idle: the second coincides with the first pop, so all fit.
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 4'h0, 8'(k + 1));
      check("burst_status", 32'(data_out), 32'h43);
      drive(1'b0, 1'b1, 4'h0, 8'h99);
      check("overflow_status", 32'(data_out), 32'h4B);
      drive(1'b0, 1'b1, 4'h1, 8'h04);
      drive(1'b0, 1'b0, 4'h0, 8'h00);
      check("flush_status", 32'(data_out), 32'h0D);
      drive(1'b0, 1'b1, 4'h1, 8'h02);
      drive(1'b0, 1'b0, 4'h0, 8'h00);
      check("ovf_clear_status", 32'(data_out), 32'h05);
      wait_idle(700);
      check("idle_status", 32'(data_out), 32'h04);

      // Reset while the line is high.
      drive(1'b0, 1'b1, 4'h0, 8'h80);
      repeat (3) drive(1'b0, 1'b0, 4'h0, 8'h00);
      check("pre_reset_dout", 32'(uo_out), 32'h03);
      drive(1'b1, 1'b0, 4'h0, 8'h00);
      check("mid_bit_reset_uo", 32'(uo_out), 32'h00);
      check("mid_bit_reset_status", 32'(data_out), 32'h04);
      drive(1'b0, 1'b0, 4'h0, 8'h00);

      // Randomized register traffic against the model.
      for (int i = 0; i < 25000; i++) begin
         r = $urandom_range(0, 999);
         if ($urandom_range(0, 4999) == 0)
            drive(1'b1, 1'b0, 4'h0, 8'h00);
         else if (r < 12)
            drive(1'b0, 1'b1, 4'h0, 8'($urandom));
         else if (r < 16)
            drive(1'b0, 1'b1, 4'h1, {5'b0, ($urandom_range(0, 3) == 0),
                                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0)});
         else if (r < 18)
            drive(1'b0, 1'b1, 4'($urandom_range(2, 15)), 8'($urandom));
         else
            drive(1'b0, 1'b0, 4'($urandom_range(0, 3)), 8'h00);
      end
      drive(1'b0, 1'b0, 4'h0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 SHALL have parameter T0H_CYC, 22, high-phase cycles for a 0 bit.
REQ-002 SHALL have parameter T1H_CYC, 45, high-phase cycles for a 1 bit.
REQ-003 SHALL have parameter BIT_CYC, 80, total cycles per bit (1.25 us at 64 MHz).
REQ-004 SHALL have parameter RES_CYC, 3840, latch/reset low time in cycles (60 us).
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port address, input, 4, register address from the SPI register stage.
REQ-008 SHALL have port data_in, input, 8, write data.
REQ-009 SHALL have port data_write, input, 1, one-cycle write strobe.
REQ-010 SHALL have port data_out, output, 8, read data, combinational from address.
REQ-011 SHALL have port uo_out, output, 8: [0] dout serial line, [1] busy, [7:2] 0.

Function
REQ-012 SHALL provide a 4-entry byte FIFO. A write to address 0x0 pushes data_in.
REQ-013 A push SHALL be accepted when level<4, or when a pop occurs in the same cycle.
REQ-014 A push in any other case SHALL be dropped and SHALL set sticky overflow.
REQ-015 A write to 0x1 SHALL act on data_in bits: [0] set latch_pend, [1] clear overflow, [2] flush FIFO (level=0); all three may act together.
REQ-016 Flush SHALL NOT abort the byte currently shifting.
REQ-017 Writes to addresses 0x2..0xF SHALL be ignored.
REQ-018 Reading 0x0 SHALL return {1'b0, level[2:0], overflow, empty, full, busy}.
REQ-019 Reading 0x1 SHALL return {7'b0, latch_pend}. All other addresses SHALL read 0x00.
REQ-020 The FSM SHALL have states IDLE, HIGH, LOW, LATCH. busy SHALL be 1 in any state other than IDLE.
REQ-021 In IDLE with FIFO non-empty, the block SHALL pop into an 8-bit shift register and enter HIGH the next cycle. dout therefore rises 2 cycles after the data_write cycle of a push into an empty FIFO.
REQ-022 In IDLE with FIFO empty and latch_pend=1, the FSM SHALL enter LATCH.
REQ-023 Bits SHALL be sent MSB first. HIGH drives dout=1 for T0H_CYC or T1H_CYC cycles, then LOW drives dout=0 so the bit totals exactly BIT_CYC cycles.
REQ-024 At the end of a non-final bit, the FSM SHALL go to HIGH for the next bit with no gap.
REQ-025 At the end of bit 0: if FIFO non-empty, pop and go to HIGH (no gap, back-to-back bytes); else if latch_pend, go to LATCH; else go to IDLE.
REQ-026 LATCH SHALL hold dout=0 for RES_CYC cycles, clear latch_pend on exit, and return to IDLE.
REQ-027 Pushes during LATCH SHALL queue and transmit after LATCH ends.
REQ-028 A latch request arriving in the same cycle the FSM exits LATCH SHALL remain pending.
REQ-029 The bit-timing counter SHALL be 12 bits wide and SHALL count 0..N-1 without wrap artefacts.

Reset
REQ-030 While rst=1 at a clk edge: FSM=IDLE, FIFO level=0, overflow=0, latch_pend=0, counters=0, shift register=0.
REQ-031 While rst=1 at a clk edge: uo_out=0x00 from the following cycle.
REQ-032 Reset mid-byte or mid-LATCH SHALL abort immediately with no further dout pulses.
REQ-033 data_out SHALL read 0x04 (empty only) after reset.

Verification
REQ-034 Write 0xA5 to 0x0 -> dout rises at data_write+2. Pulse pattern is 1,0,1,0,0,1,0,1 (high times of 45/22 cycles) within an 80-cycle period; FSM returns to IDLE after 640 cycles.
REQ-035 Write 5 bytes back-to-back while idle -> 4 are accepted and the 5th is accepted only if the first pop coincides with it, else overflow=1. All accepted bytes are sent contiguously, 640 cycles each, with no gap.
REQ-036 Write 0xFF, then 0x01 to 0x1 -> after the byte, dout stays low for exactly 3840 cycles with busy=1. Then latch_pend=0 and busy=0.
REQ-037 Push 0x00 during LATCH -> the byte starts on the cycle after LATCH exits.
REQ-038 Fill the FIFO during a transmission, write 0x04 to 0x1 -> level reads 0, the current byte completes, then IDLE.
REQ-039 Assert rst mid-bit while dout=1 -> uo_out=0x00 the next cycle and status reads 0x04.
